act_bitserial_feeder: RTL

- Write-back and input side of the CIM loop, at the opposite end of the NMC aggregation interface.
- Accepts ReLU-quantised activation vectors into a small FIFO.
- Streams each vector into the CIM array bit-serially, MSB plane first, one plane per cycle.
- Issues relu_out_en on the last plane of each vector, so the aggregator clears and the ReLU result is captured for write-back.

---
 rtl/cim_pkg.sv | 36 +++
 rtl/act_fifo.sv | 60 ++++++
 rtl/act_bitserial_feeder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cim_pkg.sv
// Shared CIM-loop definitions: activation geometry, FIFO sizing, feeder FSM states
// and the vector/plane types exchanged with the NMC aggregator.
package cim_pkg;
    localparam int ACT_PRECISION = 4;
    localparam int DIM           = 64;
    localparam int DEPTH         = 8;
    localparam int ADDR_W        = 3;
    localparam int BIT_W         = 2;
    localparam int CNT_W         = ADDR_W + 1;
    localparam int VEC_W         = ACT_PRECISION * DIM;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [BIT_W-1:0] TOP_BIT  = BIT_W'(ACT_PRECISION - 1);

    typedef logic [VEC_W-1:0] act_vec_t;
    typedef logic [DIM-1:0]   act_plane_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        STALL,
        FIN
    } feed_state_t;

    // Bit b of every element, element i landing on plane bit i.
    function automatic act_plane_t get_plane(input act_vec_t vec, input logic [BIT_W-1:0] b);
        act_plane_t                 plane;
        logic [ACT_PRECISION-1:0]   elem;
        plane = '0;
        for (int i = 0; i < DIM; i++) begin
            elem     = ACT_PRECISION'(vec >> (i * ACT_PRECISION));
            plane[i] = elem[b];
        end
        return plane;
    endfunction
endpackage

// File: rtl/act_fifo.sv
// Synchronous FIFO of activation vectors. The head and the entry behind it are both
// readable combinationally so the feeder can roll onto the next vector without a bubble.
module act_fifo
    import cim_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [VEC_W-1:0] din,
    output logic [VEC_W-1:0] dout,
    output logic [VEC_W-1:0] dout_next,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [VEC_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_rdPtrNext;

    assign full        = (r_count == FULL_CNT);
    assign empty       = (r_count == '0);
    assign count       = r_count;
    assign w_push      = push && !full;
    assign w_pop       = pop && !empty;
    assign w_rdPtrNext = r_rdPtr + ADDR_W'(1);
    assign dout        = r_mem[r_rdPtr];
    // With a single entry, the vector behind the head is the one being pushed right now.
    assign dout_next   = (r_count > CNT_W'(1)) ? r_mem[w_rdPtrNext] : din;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= w_rdPtrNext;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/act_bitserial_feeder.sv
// Buffers write-back activation vectors and streams them into the CIM array one
// bit plane per cycle, MSB first, flagging plane 0 so the NMC side captures its ReLU result.
module act_bitserial_feeder
    import cim_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [VEC_W-1:0] wb_data,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    output logic             busy,
    output logic             done,
    output logic [DIM-1:0]   cim_in,
    output logic             cim_in_valid,
    output logic [BIT_W-1:0] bit_idx,
    output logic             relu_out_en,
    output logic [CNT_W-1:0] count
);
    feed_state_t      r_state;
    feed_state_t      w_stateNext;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_remNext;
    logic [DIM-1:0]   r_cimIn;
    logic [DIM-1:0]   w_planeNext;
    logic             r_valid;
    logic             w_validNext;
    logic [BIT_W-1:0] r_bitIdx;
    logic [BIT_W-1:0] w_bitNext;
    logic             r_relu;
    logic             w_reluNext;
    logic             r_done;
    logic             w_doneNext;
    logic             r_busy;
    logic             w_busyNext;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [VEC_W-1:0] w_head;
    logic [VEC_W-1:0] w_headNext;

    assign wb_ready     = !w_full;
    assign w_push       = wb_valid && wb_ready;
    assign w_pop        = (r_state == STREAM) && (r_bitIdx == '0);
    assign busy         = r_busy;
    assign done         = r_done;
    assign cim_in       = r_cimIn;
    assign cim_in_valid = r_valid;
    assign bit_idx      = r_bitIdx;
    assign relu_out_en  = r_relu;
    assign count        = w_count;

    act_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .din       (wb_data),
        .dout      (w_head),
        .dout_next (w_headNext),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Next-state logic computes the registered output values for the following cycle.
    always_comb begin
        w_stateNext = r_state;
        w_remNext   = r_remaining;
        w_planeNext = r_cimIn;
        w_validNext = 1'b0;
        w_bitNext   = r_bitIdx;
        w_reluNext  = 1'b0;
        w_doneNext  = 1'b0;
        w_busyNext  = r_busy;
        case (r_state)
            IDLE: begin
                w_bitNext = TOP_BIT;
                if (start) begin
                    if (num_vec == '0) begin
                        w_stateNext = FIN;
                        w_doneNext  = 1'b1;
                        w_busyNext  = 1'b0;
                    end else begin
                        w_remNext  = num_vec;
                        w_busyNext = 1'b1;
                        if (!w_empty) begin
                            w_stateNext = STREAM;
                            w_validNext = 1'b1;
                            w_planeNext = get_plane(w_head, TOP_BIT);
                        end else begin
                            w_stateNext = STALL;
                        end
                    end
                end
            end
            STREAM: begin
                if (r_bitIdx != '0) begin
                    w_validNext = 1'b1;
                    w_bitNext   = r_bitIdx - BIT_W'(1);
                    w_planeNext = get_plane(w_head, r_bitIdx - BIT_W'(1));
                    w_reluNext  = (r_bitIdx == BIT_W'(1));
                end else begin
                    w_remNext = r_remaining - CNT_W'(1);
                    w_bitNext = TOP_BIT;
                    if (r_remaining == CNT_W'(1)) begin
                        w_stateNext = FIN;
                        w_doneNext  = 1'b1;
                        w_busyNext  = 1'b0;
                    end else if ((w_count == CNT_W'(1)) && !w_push) begin
                        w_stateNext = STALL;
                    end else begin
                        w_validNext = 1'b1;
                        w_planeNext = get_plane(w_headNext, TOP_BIT);
                    end
                end
            end
            STALL: begin
                if (!w_empty) begin
                    w_stateNext = STREAM;
                    w_validNext = 1'b1;
                    w_bitNext   = TOP_BIT;
                    w_planeNext = get_plane(w_head, TOP_BIT);
                end
            end
            FIN: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_cimIn     <= '0;
            r_valid     <= 1'b0;
            r_bitIdx    <= TOP_BIT;
            r_relu      <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_remaining <= w_remNext;
            r_cimIn     <= w_planeNext;
            r_valid     <= w_validNext;
            r_bitIdx    <= w_bitNext;
            r_relu      <= w_reluNext;
            r_done      <= w_doneNext;
            r_busy      <= w_busyNext;
        end
    end
endmodule
